// File: rtl/enduro_multi_sync.sv
// enduro_multi_sync: per-channel flop-chain synchronizer with an optional stability
// filter and registered rise/fall event pulses, all clocked by dst_clk.
module enduro_multi_sync #(
    parameter int               WIDTH         = 4,
    parameter int               SYNC_STAGES   = 3,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
    input  logic             dst_clk,
    input  logic             dst_reset_n,
    input  logic [WIDTH-1:0] async_in,
    input  logic             hold,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    localparam int CNT_W = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("enduro_multi_sync: WIDTH must be 1..32");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 6) begin : g_bad_stages
            $error("enduro_multi_sync: SYNC_STAGES must be 2..6");
        end
        if (FILTER_CYCLES < 0 || FILTER_CYCLES > 255) begin : g_bad_filter
            $error("enduro_multi_sync: FILTER_CYCLES must be 0..255");
        end
    endgenerate

    // True on the edge where one more increment would reach FILTER_CYCLES.
    function automatic logic cnt_at_limit(input logic [CNT_W-1:0] cnt);
        return (int'(cnt) + 1) >= FILTER_CYCLES;
    endfunction

    // ---- stage p0: metastability chain, one row of flops per stage ----
    logic [WIDTH-1:0] chain_p0 [SYNC_STAGES];
    logic [WIDTH-1:0] synced_p0;

    always_ff @(posedge dst_clk or negedge dst_reset_n) begin
        if (!dst_reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                chain_p0[k] <= RESET_VAL;
            end
        end else begin
            chain_p0[0] <= async_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                chain_p0[k] <= chain_p0[k-1];
            end
        end
    end

    assign synced_p0 = chain_p0[SYNC_STAGES-1];

    // ---- stage p1: filter / output register; stage p2: event pulses ----
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic out_p1;
        logic rise_p2;
        logic fall_p2;
        logic differs;

        assign differs = synced_p0[i] ^ out_p1;

        if (FILTER_CYCLES > 0) begin : g_filt
            logic [CNT_W-1:0] cnt_p1;

            always_ff @(posedge dst_clk or negedge dst_reset_n) begin
                if (!dst_reset_n) begin
                    cnt_p1  <= '0;
                    out_p1  <= RESET_VAL[i];
                    rise_p2 <= 1'b0;
                    fall_p2 <= 1'b0;
                end else if (hold) begin
                    rise_p2 <= 1'b0;
                    fall_p2 <= 1'b0;
                end else if (!differs) begin
                    cnt_p1  <= '0;
                    rise_p2 <= 1'b0;
                    fall_p2 <= 1'b0;
                end else if (cnt_at_limit(cnt_p1)) begin
                    cnt_p1  <= '0;
                    out_p1  <= synced_p0[i];
                    rise_p2 <= synced_p0[i];
                    fall_p2 <= ~synced_p0[i];
                end else begin
                    cnt_p1  <= cnt_p1 + CNT_W'(1);
                    rise_p2 <= 1'b0;
                    fall_p2 <= 1'b0;
                end
            end
        end else begin : g_bypass
            always_ff @(posedge dst_clk or negedge dst_reset_n) begin
                if (!dst_reset_n) begin
                    out_p1  <= RESET_VAL[i];
                    rise_p2 <= 1'b0;
                    fall_p2 <= 1'b0;
                end else if (hold) begin
                    rise_p2 <= 1'b0;
                    fall_p2 <= 1'b0;
                end else begin
                    out_p1  <= synced_p0[i];
                    rise_p2 <= differs & synced_p0[i];
                    fall_p2 <= differs & ~synced_p0[i];
                end
            end
        end

        assign sync_out[i]   = out_p1;
        assign rise_pulse[i] = rise_p2;
        assign fall_pulse[i] = fall_p2;
    end

    assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_enduro_multi_sync.sv
// Bench for enduro_multi_sync: two configurations checked every cycle against a
// behavioural model, plus directed scenarios with hand-computed expectations.
module tb_enduro_multi_sync;

    localparam int         SA = 3, FA = 4;
    localparam logic [3:0] RA = 4'h0;
    localparam int         SB = 2, FB = 0;
    localparam logic [3:0] RB = 4'hF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a_a, a_b;
    logic       hold_a, hold_b;
    logic [3:0] sync_out_a, rise_a, fall_a;
    logic [3:0] sync_out_b, rise_b, fall_b;
    logic       any_a, any_b;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    enduro_multi_sync #(.WIDTH(4), .SYNC_STAGES(SA), .FILTER_CYCLES(FA), .RESET_VAL(RA)) dut_a (
        .dst_clk(clk), .dst_reset_n(rst_n), .async_in(a_a), .hold(hold_a),
        .sync_out(sync_out_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .any_change(any_a)
    );

    enduro_multi_sync #(.WIDTH(4), .SYNC_STAGES(SB), .FILTER_CYCLES(FB), .RESET_VAL(RB)) dut_b (
        .dst_clk(clk), .dst_reset_n(rst_n), .async_in(a_b), .hold(hold_b),
        .sync_out(sync_out_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .any_change(any_b)
    );

    // Model state, index 0 = dut_a, 1 = dut_b
    logic [3:0] m_pipe [2][6];
    logic [3:0] m_out  [2];
    logic [3:0] m_rise [2];
    logic [3:0] m_fall [2];
    int         m_run  [2][4];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 6; k++) m_pipe[d][k] = (d == 0) ? RA : RB;
            m_out[d]  = (d == 0) ? RA : RB;
            m_rise[d] = 4'h0;
            m_fall[d] = 4'h0;
            for (int c = 0; c < 4; c++) m_run[d][c] = 0;
        end
    endtask

    // One clock edge: a level must differ from the output for max(F,1) un-held
    // edges in a row (hold pauses the run, agreement restarts it) to be accepted.
    task automatic model_step(input int d, input logic [3:0] a, input logic h);
        logic [3:0] s;
        int         stages, lim;
        stages    = (d == 0) ? SA : SB;
        lim       = (d == 0) ? ((FA > 0) ? FA : 1) : ((FB > 0) ? FB : 1);
        s         = m_pipe[d][stages-1];
        m_rise[d] = 4'h0;
        m_fall[d] = 4'h0;
        if (!h) begin
            for (int c = 0; c < 4; c++) begin
                if (s[c] == m_out[d][c]) begin
                    m_run[d][c] = 0;
                end else begin
                    m_run[d][c]++;
                    if (m_run[d][c] >= lim) begin
                        m_out[d][c] = s[c];
                        m_run[d][c] = 0;
                        if (s[c]) m_rise[d][c] = 1'b1;
                        else      m_fall[d][c] = 1'b1;
                    end
                end
            end
        end
        for (int k = 5; k > 0; k--) m_pipe[d][k] = m_pipe[d][k-1];
        m_pipe[d][0] = a;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0, a_a, hold_a);
            model_step(1, a_b, hold_b);
        end
    end

    always @(negedge clk) begin
        check("sync_out_a", sync_out_a, m_out[0]);
        check("rise_a",     rise_a,     m_rise[0]);
        check("fall_a",     fall_a,     m_fall[0]);
        check("any_a",      {3'b0, any_a}, {3'b0, |(m_rise[0] | m_fall[0])});
        check("sync_out_b", sync_out_b, m_out[1]);
        check("rise_b",     rise_b,     m_rise[1]);
        check("fall_b",     fall_b,     m_fall[1]);
        check("any_b",      {3'b0, any_b}, {3'b0, |(m_rise[1] | m_fall[1])});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n  = 1'b0;
        a_a    = 4'h0;
        a_b    = 4'hF;
        hold_a = 1'b0;
        hold_b = 1'b0;
        tick(3);
        check("reset_sync_a", sync_out_a, 4'h0);
        check("reset_rise_a", rise_a, 4'h0);
        check("reset_fall_a", fall_a, 4'h0);
        check("reset_any_a",  {3'b0, any_a}, 4'h0);
        check("reset_sync_b", sync_out_b, 4'hF);

        // Latency: captured at edge 1 -> dut_a output after edge 7, dut_b after edge 3
        rst_n = 1'b1;
        a_a   = 4'b0001;
        a_b   = 4'b0111;
        tick(2);
        check("b_before_edge3", sync_out_b, 4'hF);
        tick(1);
        check("b_after_edge3",  sync_out_b, 4'b0111);
        check("b_fall_edge3",   fall_b,     4'b1000);
        tick(3);
        check("a_before_edge7", sync_out_a, 4'h0);
        tick(1);
        check("a_after_edge7",  sync_out_a, 4'b0001);
        check("a_rise_edge7",   rise_a,     4'b0001);
        check("a_any_edge7",    {3'b0, any_a}, 4'b0001);
        tick(1);
        check("a_any_edge8",    {3'b0, any_a}, 4'h0);

        // Glitch of 3 cycles rejected, 4 cycles accepted
        a_a = 4'b0011; tick(3);
        a_a = 4'b0001; tick(10);
        check("glitch3_sync", sync_out_a, 4'b0001);
        a_a = 4'b0011; tick(4);
        a_a = 4'b0001; tick(3);
        check("glitch4_sync", sync_out_a, 4'b0011);
        check("glitch4_rise", rise_a,     4'b0010);
        tick(4);
        check("glitch4_fall", fall_a,     4'b0010);
        check("glitch4_back", sync_out_a, 4'b0001);

        // Simultaneous rises
        a_a = 4'b0000; tick(10);
        a_a = 4'b1010; tick(7);
        check("simul_rise", rise_a,     4'b1010);
        check("simul_fall", fall_a,     4'b0000);
        check("simul_sync", sync_out_a, 4'b1010);
        tick(1);

        // Hold at counter=2 on channel 2
        a_a = 4'b1110; tick(5);
        hold_a = 1'b1; tick(5);
        check("hold_frozen", sync_out_a, 4'b1010);
        hold_a = 1'b0; tick(1);
        check("hold_rel1", sync_out_a, 4'b1010);
        tick(1);
        check("hold_rel2", sync_out_a, 4'b1110);
        check("hold_rise", rise_a,     4'b0100);

        // Asynchronous reset with channel 0 mid-filter
        a_a = 4'b1111; tick(6);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sync_a", sync_out_a, 4'h0);
        check("async_rst_rise_a", rise_a,     4'h0);
        check("async_rst_any_a",  {3'b0, any_a}, 4'h0);
        check("async_rst_sync_b", sync_out_b, 4'hF);
        a_a = 4'h0;
        a_b = 4'hF;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("post_rst_sync_a", sync_out_a, 4'h0);

        // Randomized phase with one mid-run reset
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 5) == 0) a_a[c] = ~a_a[c];
                if ($urandom_range(0, 3) == 0) a_b[c] = ~a_b[c];
            end
            hold_a = ($urandom_range(0, 9) == 0);
            hold_b = ($urandom_range(0, 9) == 0);
            if (n == 200) begin
                #2 rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
            tick(1);
        end
        hold_a = 1'b0;
        hold_b = 1'b0;
        tick(12);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
